formula_eval_sequencer: RTL
===========================

// Module: formula_eval_sequencer
// PURPOSE
//  Sequential driver for one combinational check formula (N_VARS inputs, 1-bit output o_1).
//  Enumerates every assignment of the free (unmasked) inputs and applies each one to the formula.
//  Stops at the first assignment where the formula output is 0 and reports that counterexample.
//  Reports PROVED if all assignments give 1; reports INCOMPLETE on abort or when the eval budget runs out.
// PARAMETERS
//  N_VARS       55  width of the formula input vector
//  FORMULA_LAT  0   cycles from fm_in change to valid fm_out (0 = purely combinational)
//  CNT_W        32  width of the evaluation counter and budget
// PORTS
//  clk         in   1        single clock; all state on rising edge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        1-cycle request to begin a run; ignored while busy
//  abort       in   1        stop the current run at the next edge
//  fixed_mask  in   N_VARS   1 = bit held at fixed_val; 0 = bit enumerated; sampled on accepted start
//  fixed_val   in   N_VARS   values for masked bits; sampled on accepted start
//  max_evals   in   CNT_W    eval budget, 0 = unlimited; sampled on accepted start
//  fm_in       out  N_VARS   vector driven into the formula instance
//  fm_out      in   1        formula output (o_1)
//  busy        out  1        high from the edge that accepts start until the run ends
//  done        out  1        1-cycle pulse when a run ends
//  status      out  2        00 none, 01 PROVED, 10 CEX, 11 INCOMPLETE; held until next start
//  cex_vec     out  N_VARS   failing vector; valid when status=10
//  eval_cnt    out  CNT_W    number of vectors checked in the current/last run
// BEHAVIOUR
//  Reset: state IDLE; fm_in=0, busy=0, done=0, status=00, cex_vec=0, eval_cnt=0. Internal regs cleared.
//  States: IDLE, EVAL, CHECK, DONE.
//  IDLE
//   - start=1 and abort=0: latch mask/val/budget; cur=fixed_val&fixed_mask; eval_cnt=0.
//   - Also set status=00, busy=1, then go to EVAL (or CHECK if FORMULA_LAT=0).
//  EVAL: wait counter counts FORMULA_LAT cycles with fm_in=cur held stable, then go to CHECK.
//  CHECK: sample fm_out and increment eval_cnt.
//   - fm_out=0 -> cex_vec=cur, status=10, go to DONE.
//   - Else if all free bits of cur are 1 (last vector) -> status=01, go to DONE.
//   - Else if max_evals!=0 and the new eval_cnt==max_evals -> status=11, go to DONE.
//   - Else cur=next(cur); go to EVAL (or stay in CHECK if FORMULA_LAT=0).
//   - Check priority: CEX > PROVED > budget.
//  next(cur) = (((cur|mask)+1) & ~mask) | (val&mask).
//   - This is a masked increment: masked bits are never altered; a carry ripples through free bits only.
//  DONE: done=1 and busy=0 for exactly this cycle, then go to IDLE. Status and cex_vec hold until the next accepted start.
//  Throughput: one vector per FORMULA_LAT+1 cycles. fm_in = cur at all times and changes only on CHECK exits.
//  All mask bits set (no free bits): exactly one vector is checked; result is PROVED or CEX.
//  abort=1 in EVAL or CHECK: status=11, go to DONE; fm_out is not sampled that cycle.
//  abort in IDLE or DONE has no effect. Abort wins over start in the same cycle.
//  start while busy or in DONE: ignored.
//  rst mid-run: all outputs return to their reset values at the next edge; no done pulse.
//  eval_cnt saturates at all-ones and does not wrap.
// TESTING
//  (N_VARS=4, FORMULA_LAT=0, bench formula = ~&v)
//  T1 start, mask=0 -> CEX at vec=4'hF, eval_cnt=16, done 16 cycles after the start edge.
//  T2 formula = 1, mask=4'b1010, val=4'b1000 -> vectors 8,9,C,D in order; PROVED; eval_cnt=4.
//  T3 formula = 1, mask=0, max_evals=5 -> status=11, eval_cnt=5, cex_vec unchanged.
//  T4 FORMULA_LAT=3, formula = ~(v==4'h6) -> CEX vec=6, eval_cnt=7; fm_in stable for 4 cycles per vector.
//  T5 abort on the 3rd CHECK -> status=11, eval_cnt=2; start during the run is ignored.
//  T6 rst mid-run -> all outputs 0 next cycle; a new start then runs normally from the first vector.

Source files
------------

// File: rtl/formula_eval_sequencer.sv
// -----------------------------------------------------------------------------
// formula_eval_sequencer
// Drives one combinational check formula through every assignment of its free
// (unmasked) inputs. The run stops at the first vector that makes the formula
// output 0 and reports that vector as a counterexample. If every vector gives 1
// the run reports PROVED. An abort, or an exhausted evaluation budget, reports
// INCOMPLETE.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : 1-cycle run request, accepted only in IDLE
//   abort      : ends the current run at the next edge (status INCOMPLETE)
//   fixed_mask : 1 = bit held at fixed_val, 0 = bit enumerated (latched on start)
//   fixed_val  : values for the held bits (latched on start)
//   max_evals  : evaluation budget, 0 = unlimited (latched on start)
//   fm_in      : vector applied to the formula instance
//   fm_out     : formula result
//   busy       : high while a run is in progress
//   done       : 1-cycle pulse when a run ends
//   status     : 00 none, 01 PROVED, 10 CEX, 11 INCOMPLETE
//   cex_vec    : failing vector, valid when status = 10
//   eval_cnt   : vectors checked in the current/last run (saturating)
// -----------------------------------------------------------------------------
module formula_eval_sequencer #(
   parameter int N_VARS      = 55,
   parameter int FORMULA_LAT = 0,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [N_VARS-1:0] fixed_mask,
   input  logic [N_VARS-1:0] fixed_val,
   input  logic [CNT_W-1:0]  max_evals,
   output logic [N_VARS-1:0] fm_in,
   input  logic              fm_out,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [N_VARS-1:0] cex_vec,
   output logic [CNT_W-1:0]  eval_cnt
);

   localparam int WAIT_W = (FORMULA_LAT > 1) ? $clog2(FORMULA_LAT) : 1;
   // Wait-counter value on the last EVAL cycle; unused when FORMULA_LAT is 0.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((FORMULA_LAT > 0) ? (FORMULA_LAT - 1) : 0);

   localparam logic [1:0] ST_NONE       = 2'b00;
   localparam logic [1:0] ST_PROVED     = 2'b01;
   localparam logic [1:0] ST_CEX        = 2'b10;
   localparam logic [1:0] ST_INCOMPLETE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EVAL  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state,  w_state;
   logic [N_VARS-1:0]   r_mask,   w_mask;
   logic [N_VARS-1:0]   r_val,    w_val;
   logic [CNT_W-1:0]    r_budget, w_budget;
   logic [N_VARS-1:0]   r_cur,    w_cur;
   logic [WAIT_W-1:0]   r_wait,   w_wait;
   logic                r_busy,   w_busy;
   logic                r_done,   w_done;
   logic [1:0]          r_status, w_status;
   logic [N_VARS-1:0]   r_cex,    w_cex;
   logic [CNT_W-1:0]    r_cnt,    w_cnt;

   logic [CNT_W-1:0]    w_cnt_inc;
   logic                w_last;
   logic [N_VARS-1:0]   w_next_cur;

   // Saturating count; the last vector is the one whose free bits are all 1.
   // The masked increment forces held bits to 1 so the carry skips over them.
   assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : (r_cnt + CNT_W'(1));
   assign w_last     = ((r_cur | r_mask) == {N_VARS{1'b1}});
   assign w_next_cur = (((r_cur | r_mask) + N_VARS'(1)) & ~r_mask) | (r_val & r_mask);

   // Next-state and next-output logic for the run sequencer.
   always_comb begin
      w_state  = r_state;
      w_mask   = r_mask;
      w_val    = r_val;
      w_budget = r_budget;
      w_cur    = r_cur;
      w_wait   = r_wait;
      w_busy   = r_busy;
      w_done   = 1'b0;
      w_status = r_status;
      w_cex    = r_cex;
      w_cnt    = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_mask   = fixed_mask;
               w_val    = fixed_val;
               w_budget = max_evals;
               w_cur    = fixed_val & fixed_mask;
               w_cnt    = {CNT_W{1'b0}};
               w_wait   = {WAIT_W{1'b0}};
               w_status = ST_NONE;
               w_busy   = 1'b1;
               w_state  = (FORMULA_LAT == 0) ? S_CHECK : S_EVAL;
            end else begin
               w_state  = S_IDLE;
            end
         end
         S_EVAL: begin
            if (abort) begin
               w_status = ST_INCOMPLETE;
               w_busy   = 1'b0;
               w_done   = 1'b1;
               w_state  = S_DONE;
            end else if (r_wait == WAIT_LAST) begin
               w_state  = S_CHECK;
            end else begin
               w_wait   = r_wait + WAIT_W'(1);
            end
         end
         S_CHECK: begin
            if (abort) begin
               // fm_out is deliberately ignored on an abort cycle
               w_status = ST_INCOMPLETE;
               w_busy   = 1'b0;
               w_done   = 1'b1;
               w_state  = S_DONE;
            end else begin
               w_cnt = w_cnt_inc;
               if (!fm_out) begin
                  w_cex    = r_cur;
                  w_status = ST_CEX;
                  w_busy   = 1'b0;
                  w_done   = 1'b1;
                  w_state  = S_DONE;
               end else if (w_last) begin
                  w_status = ST_PROVED;
                  w_busy   = 1'b0;
                  w_done   = 1'b1;
                  w_state  = S_DONE;
               end else if ((r_budget != {CNT_W{1'b0}}) && (w_cnt_inc == r_budget)) begin
                  w_status = ST_INCOMPLETE;
                  w_busy   = 1'b0;
                  w_done   = 1'b1;
                  w_state  = S_DONE;
               end else begin
                  w_cur    = w_next_cur;
                  w_wait   = {WAIT_W{1'b0}};
                  w_state  = (FORMULA_LAT == 0) ? S_CHECK : S_EVAL;
               end
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mask   <= {N_VARS{1'b0}};
         r_val    <= {N_VARS{1'b0}};
         r_budget <= {CNT_W{1'b0}};
         r_cur    <= {N_VARS{1'b0}};
         r_wait   <= {WAIT_W{1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_status <= ST_NONE;
         r_cex    <= {N_VARS{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
      end else begin
         r_state  <= w_state;
         r_mask   <= w_mask;
         r_val    <= w_val;
         r_budget <= w_budget;
         r_cur    <= w_cur;
         r_wait   <= w_wait;
         r_busy   <= w_busy;
         r_done   <= w_done;
         r_status <= w_status;
         r_cex    <= w_cex;
         r_cnt    <= w_cnt;
      end
   end

   assign fm_in    = r_cur;
   assign busy     = r_busy;
   assign done     = r_done;
   assign status   = r_status;
   assign cex_vec  = r_cex;
   assign eval_cnt = r_cnt;

endmodule
